// File: rtl/rv_wb_pkg.sv
// Shared constants and the buffered-result layout for the writeback arbiter.
package rv_wb_pkg;

  localparam int N_REGS_DEF       = 32;
  localparam int R_WIDTH_DEF      = 32;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int W_ADDR_DEF       = $clog2(N_REGS_DEF);

  // One buffered long-latency result; the arbiter uses this layout, sized by its parameters.
  typedef struct packed {
    logic [W_ADDR_DEF-1:0]  addr;
    logic [R_WIDTH_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering long-latency writeback results.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// Merges single-cycle ALU results and buffered long-latency results onto the
// register file's single write port, with a starvation guard for the buffer.
module writeback_arbiter
  import rv_wb_pkg::*;
#(
  parameter int N_REGS       = N_REGS_DEF,
  parameter int R_WIDTH      = R_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  localparam int W_ADDR      = $clog2(N_REGS),
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [W_ADDR-1:0]  alu_rd,
  input  logic [R_WIDTH-1:0] alu_data,
  input  logic               lsu_valid,
  output logic               lsu_ready,
  input  logic [W_ADDR-1:0]  lsu_rd,
  input  logic [R_WIDTH-1:0] lsu_data,
  output logic               rs0_write,
  output logic [W_ADDR-1:0]  rs0_addr,
  output logic [R_WIDTH-1:0] rs0_data_in,
  output logic [CW-1:0]      fifo_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [W_ADDR-1:0]  addr;
    logic [R_WIDTH-1:0] data;
  } entry_t;

  function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] c);
    return (c == SW'(STARVE_LIMIT)) ? c : c + 1'b1;
  endfunction

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          force_drain;
  logic [SW-1:0] starve_cnt;
  entry_t        head;
  entry_t        lsu_entry;

  // Stage 0: grant selection and buffer control
  assign force_drain = ~empty & (starve_cnt == SW'(STARVE_LIMIT));
  assign alu_ready   = ~force_drain;
  assign lsu_ready   = ~full;
  assign push        = lsu_valid & ~full & (lsu_rd != '0);
  assign pop         = force_drain | (~alu_valid & ~empty);
  assign lsu_entry   = '{addr: lsu_rd, data: lsu_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (lsu_entry),
    .full  (full),
    .empty (empty),
    .count (fifo_count),
    .head  (head)
  );

  // Stage 1: registered write port; address/data hold while no write issues
  always_ff @(posedge clk) begin
    if (rst) begin
      rs0_write   <= 1'b0;
      rs0_addr    <= '0;
      rs0_data_in <= '0;
      starve_cnt  <= '0;
    end else if (force_drain) begin
      rs0_write   <= 1'b1;
      rs0_addr    <= head.addr;
      rs0_data_in <= head.data;
      starve_cnt  <= '0;
    end else if (alu_valid) begin
      rs0_write  <= (alu_rd != '0);
      starve_cnt <= empty ? '0 : starve_inc(starve_cnt);
      if (alu_rd != '0) begin
        rs0_addr    <= alu_rd;
        rs0_data_in <= alu_data;
      end
    end else if (!empty) begin
      rs0_write   <= 1'b1;
      rs0_addr    <= head.addr;
      rs0_data_in <= head.data;
      starve_cnt  <= '0;
    end else begin
      rs0_write <= 1'b0;
    end
  end

endmodule
